set_assoc_cache: RTL

Parametrised N-way set-associative data cache. It sits between the CPU load/store stage and data memory. Write-through, no-write-allocate; read misses refill one word from memory over a valid/ready interface. Per-set round-robin replacement with invalid-way priority, and a single-cycle flush.

---
 rtl/cache_pkg.sv | 37 +++
 rtl/cache_victim_sel.sv | 27 ++
 rtl/set_assoc_cache.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache family.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MISS_REQ  = 3'd1,
        MISS_WAIT = 3'd2,
        WR_REQ    = 3'd3,
        RESP      = 3'd4
    } cache_state_t;

    // Byte-offset bits below the word index.
    localparam int unsigned WORD_OFF_W = 2;

    // Ceiling log2 usable in constant expressions.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Way-index width; kept at least 1 bit so a direct-mapped build still has a legal vector.
    function automatic int unsigned idx_w(input int unsigned ways);
        return (ways > 1) ? clog2_f(ways) : 1;
    endfunction

    // Tag width: whatever address bits remain above the set index and byte offset.
    function automatic int unsigned tag_w(input int unsigned addr_width, input int unsigned sets);
        return addr_width - clog2_f(sets) - WORD_OFF_W;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: lowest-index invalid way, otherwise the set's round-robin pointer.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned IDX_W = idx_w(WAYS)
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] victim
);

    logic found;

    // Scan upward so the first invalid way found wins over the pointer.
    always_comb begin
        victim = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!found && !valid[i]) begin
                victim = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-through, no-write-allocate data cache with one-word lines.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    input  logic                  flush,
    output logic                  hit_o
);

    localparam int unsigned SET_W = clog2_f(SETS);
    localparam int unsigned TAG_W = tag_w(ADDR_WIDTH, SETS);
    localparam int unsigned IDX_W = idx_w(WAYS);

    // Flat per-way register files indexed by set.
    logic [SETS-1:0]       valid_q [WAYS];
    logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS];
    logic [IDX_W-1:0]      ptr_q   [SETS];

    cache_state_t          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  hit_q;

    logic [SET_W-1:0]      cur_set;
    logic [TAG_W-1:0]      cur_tag;
    logic [WAYS-1:0]       hit_vec;
    logic                  lk_hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [WAYS-1:0]       set_valid;
    logic [IDX_W-1:0]      victim;
    logic [IDX_W-1:0]      next_ptr;
    logic                  do_flush;
    logic                  do_fill;
    logic                  do_wr_upd;

    // In IDLE the lookup must see the incoming address to pick the next state;
    // everywhere else it works on the latched request.
    assign cur_set = (state_q == IDLE) ? cpu_req_addr[SET_W+1:2] : addr_q[SET_W+1:2];
    assign cur_tag = (state_q == IDLE) ? cpu_req_addr[ADDR_WIDTH-1:SET_W+2]
                                       : addr_q[ADDR_WIDTH-1:SET_W+2];

    // Parallel tag compare across all ways of the selected set.
    always_comb begin
        hit_vec  = '0;
        hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][cur_set] && (tag_q[w][cur_set] == cur_tag)) begin
                hit_vec[w] = 1'b1;
                hit_data   = data_q[w][cur_set];
            end
        end
    end

    assign lk_hit = |hit_vec;

    // Gather the selected set's valid bits for the victim selector.
    always_comb begin
        set_valid = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][cur_set];
        end
    end

    cache_victim_sel #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_victim_sel (
        .valid  (set_valid),
        .ptr    (ptr_q[cur_set]),
        .victim (victim)
    );

    assign next_ptr  = (WAYS > 1) ? (ptr_q[cur_set] + IDX_W'(1)) : '0;
    assign do_flush  = (state_q == IDLE) && !cpu_req_valid && flush;
    assign do_fill   = (state_q == MISS_WAIT) && mem_resp_valid;
    assign do_wr_upd = (state_q == WR_REQ) && mem_req_ready && lk_hit;

    // Request FSM and latched request/response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_q  <= cpu_req_addr;
                        wdata_q <= cpu_req_wdata;
                        hit_q   <= lk_hit;
                        if (cpu_req_write) begin
                            state_q <= WR_REQ;
                        end else if (lk_hit) begin
                            rdata_q <= hit_data;
                            state_q <= RESP;
                        end else begin
                            state_q <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        state_q <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= mem_resp_rdata;
                        state_q <= RESP;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Valid bits and replacement pointers: cleared by reset or flush, set/advanced on a fill.
    always_ff @(posedge clk) begin
        if (rst || do_flush) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
            for (int unsigned s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (do_fill) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (IDX_W'(w) == victim) begin
                    valid_q[w][cur_set] <= 1'b1;
                end
            end
            ptr_q[cur_set] <= next_ptr;
        end
    end

    // Tag/data storage: refill writes the victim way, a write hit updates the hitting way.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (IDX_W'(w) == victim) begin
                    tag_q[w][cur_set]  <= cur_tag;
                    data_q[w][cur_set] <= mem_resp_rdata;
                end
            end
        end else if (do_wr_upd) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (hit_vec[w]) begin
                    data_q[w][cur_set] <= wdata_q;
                end
            end
        end
    end

    assign cpu_req_ready  = (state_q == IDLE);
    assign cpu_resp_valid = (state_q == RESP);
    assign cpu_resp_rdata = rdata_q;
    assign hit_o          = hit_q;
    assign mem_req_valid  = (state_q == MISS_REQ) || (state_q == WR_REQ);
    assign mem_req_write  = (state_q == WR_REQ);
    assign mem_req_addr   = addr_q & ~ADDR_WIDTH'(3);
    assign mem_req_wdata  = wdata_q;

    // A line may live in at most one way of a set.
    a_single_match: assert property (@(posedge clk) disable iff (rst) $onehot0(hit_vec));

endmodule
